imem_boot_loader: RTL and testbench

- Boot-time controller for the 64x32 word-addressed instruction memory.
- After reset it holds the CPU in stall, zero-fills every I-MEM word, then loads a program from a valid/ready word stream.
- Once loading completes it releases the CPU and hands the memory address port to CPU fetch.
- Sits between the top-level/testbench program source, the I-MEM write port and the PC fetch path.

---
 rtl/imem_pkg.sv | 15 +
 rtl/imem_boot_loader.sv | 128 ++++++++++++
 tb/tb_imem_boot_loader.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared I-MEM geometry and boot FSM state type
package imem_pkg;

    localparam int IMEM_DEPTH  = 64;
    localparam int IMEM_ADDR_W = 6;
    localparam int INSTR_W     = 32;

    typedef enum logic [1:0] {
        BOOT_CLEAR = 2'd0,
        BOOT_LOAD  = 2'd1,
        BOOT_RUN   = 2'd2,
        BOOT_ERROR = 2'd3
    } boot_state_e;

endpackage

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - I-MEM zero-fill, stream program load, then hand-off to fetch
// Optional load checksum (ld_chk, chk_error) enabled by IMEM_BOOT_LOADER_CHECKSUM_EN.
module imem_boot_loader
    import imem_pkg::*;
#(
    parameter int DEPTH  = IMEM_DEPTH,
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DATA_W = INSTR_W,
    parameter int PC_W   = ADDR_W + 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
    input  logic [DATA_W-1:0] ld_chk,
    output logic              chk_error,
`endif
    output logic              ld_ready,
    input  logic [PC_W-1:0]   fetch_addr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              cpu_stall,
    output logic              boot_done,
    output logic              load_error,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);

    boot_state_e       state;
    logic [ADDR_W-1:0] clr_idx;
    logic [ADDR_W-1:0] wr_ptr;
    logic              chk_ok;

    // Byte offset within the fetched word is irrelevant to a word-addressed memory.
    logic unused_fetch_lsbs;
    assign unused_fetch_lsbs = &{1'b0, fetch_addr[1:0]};

`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] chk_acc;
    assign chk_ok = ((chk_acc ^ ld_data) == ld_chk);
`else
    assign chk_ok = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= BOOT_CLEAR;
            clr_idx    <= '0;
            wr_ptr     <= '0;
            word_count <= '0;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
            chk_acc    <= '0;
            chk_error  <= 1'b0;
`endif
        end else begin
            case (state)
                BOOT_CLEAR: begin
                    clr_idx <= clr_idx + ADDR_ONE;
                    if (clr_idx == LAST_IDX)
                        state <= BOOT_LOAD;
                end
                BOOT_LOAD: begin
                    if (ld_valid) begin
                        wr_ptr     <= wr_ptr + ADDR_ONE;
                        word_count <= word_count + CNT_ONE;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
                        chk_acc    <= chk_acc ^ ld_data;
                        if (ld_last && !chk_ok)
                            chk_error <= 1'b1;
`endif
                        // ld_last wins over overflow: a last word in the final slot is legal.
                        if (ld_last)
                            state <= chk_ok ? BOOT_RUN : BOOT_ERROR;
                        else if (wr_ptr == LAST_IDX)
                            state <= BOOT_ERROR;
                    end
                end
                BOOT_RUN:   state <= BOOT_RUN;
                BOOT_ERROR: state <= BOOT_ERROR;
                default:    state <= BOOT_ERROR;
            endcase
        end
    end

    // Outputs are forced to their idle values while reset is held, even though
    // the asynchronously reset state would otherwise drive a CLEAR write.
    always_comb begin
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        ld_ready   = 1'b0;
        cpu_stall  = 1'b1;
        boot_done  = 1'b0;
        load_error = 1'b0;
        if (!reset) begin
            case (state)
                BOOT_CLEAR: begin
                    mem_we   = 1'b1;
                    mem_addr = clr_idx;
                end
                BOOT_LOAD: begin
                    ld_ready  = 1'b1;
                    mem_addr  = wr_ptr;
                    mem_we    = ld_valid;
                    mem_wdata = ld_valid ? ld_data : '0;
                end
                BOOT_RUN: begin
                    mem_addr  = fetch_addr[PC_W-1:2];
                    cpu_stall = 1'b0;
                    boot_done = 1'b1;
                end
                BOOT_ERROR: begin
                    load_error = 1'b1;
                end
                default: begin
                    load_error = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - self-checking bench for imem_boot_loader
module tb_imem_boot_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ld_valid = 1'b0;
    logic [31:0] ld_data = '0;
    logic        ld_last = 1'b0;
    logic        ld_ready;
    logic [7:0]  fetch_addr = '0;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        cpu_stall;
    logic        boot_done;
    logic        load_error;
    logic [6:0]  word_count;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
    logic [31:0] ld_chk = '0;
    logic        chk_error;
`endif

    imem_boot_loader dut (
        .clk        (clk),
        .reset      (reset),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_last    (ld_last),
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
        .ld_chk     (ld_chk),
        .chk_error  (chk_error),
`endif
        .ld_ready   (ld_ready),
        .fetch_addr (fetch_addr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .cpu_stall  (cpu_stall),
        .boot_done  (boot_done),
        .load_error (load_error),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s got=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Stand-in for the I-MEM: captures every write the loader issues.
    logic [31:0] shadow_mem [64];
    int          we_cnt = 0;
    always @(posedge clk) begin
        if (mem_we) begin
            shadow_mem[mem_addr] <= mem_wdata;
            we_cnt <= we_cnt + 1;
        end
    end

    // Model: cycles since reset, words accepted, and how the load ended.
    int          m_cyc;
    int          m_acc;
    bit          m_done;
    bit          m_err;
    bit          m_chkerr;
    logic [31:0] m_xor;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_cyc = 0; m_acc = 0; m_done = 0; m_err = 0; m_chkerr = 0; m_xor = '0;
        end else if (m_cyc < 64) begin
            m_cyc = m_cyc + 1;
        end else if (!m_done && !m_err && ld_valid) begin
            m_acc = m_acc + 1;
            m_xor = m_xor ^ ld_data;
            if (ld_last) begin
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
                if (m_xor != ld_chk) begin m_err = 1; m_chkerr = 1; end
                else m_done = 1;
`else
                m_done = 1;
`endif
            end else if (m_acc == 64) begin
                m_err = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            chk("rst_we", mem_we, 0);
            chk("rst_ready", ld_ready, 0);
            chk("rst_stall", cpu_stall, 1);
            chk("rst_done", boot_done, 0);
            chk("rst_err", load_error, 0);
        end else if (m_cyc < 64) begin
            chk("clr_we", mem_we, 1);
            chk("clr_addr", mem_addr, m_cyc);
            chk("clr_wdata", mem_wdata, 0);
            chk("clr_ready", ld_ready, 0);
            chk("clr_stall", cpu_stall, 1);
            chk("clr_done", boot_done, 0);
            chk("clr_err", load_error, 0);
        end else if (m_err) begin
            chk("err_we", mem_we, 0);
            chk("err_addr", mem_addr, 0);
            chk("err_ready", ld_ready, 0);
            chk("err_stall", cpu_stall, 1);
            chk("err_done", boot_done, 0);
            chk("err_err", load_error, 1);
        end else if (m_done) begin
            chk("run_we", mem_we, 0);
            chk("run_addr", mem_addr, 32'(fetch_addr >> 2));
            chk("run_ready", ld_ready, 0);
            chk("run_stall", cpu_stall, 0);
            chk("run_done", boot_done, 1);
            chk("run_err", load_error, 0);
        end else begin
            chk("ld_ready", ld_ready, 1);
            chk("ld_we", mem_we, ld_valid);
            chk("ld_stall", cpu_stall, 1);
            chk("ld_done", boot_done, 0);
            chk("ld_err", load_error, 0);
            if (ld_valid) begin
                chk("ld_addr", mem_addr, m_acc);
                chk("ld_wdata", mem_wdata, ld_data);
            end
        end
        chk("word_count", word_count, m_acc);
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
        chk("chk_error", chk_error, m_chkerr);
`endif
    end

    task automatic do_reset();
        reset = 1'b1;
        ld_valid = 1'b0;
        ld_last = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input bit last);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        step(1);
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    initial begin
        int nz;
        for (int i = 0; i < 64; i++) shadow_mem[i] = 32'hdeadbeef;

        // Zero-fill
        do_reset();
        we_cnt = 0;
        step(64);
        @(negedge clk);
        nz = 0;
        for (int i = 0; i < 64; i++) if (shadow_mem[i] != 0) nz++;
        chk("clear_nonzero_words", nz, 0);
        chk("clear_write_count", we_cnt, 64);
        chk("load_ready", ld_ready, 1);
        chk("load_stall", cpu_stall, 1);
        step(1);

        // Three-word program
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
        ld_chk = 32'h20080020 ^ 32'h20090037 ^ 32'h01098024;
`endif
        send(32'h20080020, 0);
        send(32'h20090037, 0);
        send(32'h01098024, 1);
        @(negedge clk);
        chk("prog_done", boot_done, 1);
        chk("prog_stall", cpu_stall, 0);
        chk("prog_count", word_count, 3);
        chk("prog_w0", shadow_mem[0], 32'h20080020);
        chk("prog_w1", shadow_mem[1], 32'h20090037);
        chk("prog_w2", shadow_mem[2], 32'h01098024);
        chk("prog_w3", shadow_mem[3], 0);

        // Fetch address translation
        fetch_addr = 8'h08;
        step(1);
        @(negedge clk);
        chk("fetch_08", mem_addr, 2);
        fetch_addr = 8'h0B;
        step(1);
        @(negedge clk);
        chk("fetch_0b", mem_addr, 2);
        chk("fetch_we", mem_we, 0);
        fetch_addr = 8'hFF;
        step(2);

        // Gapped handshakes; stray ld_last without ld_valid must be ignored
        do_reset();
        step(64);
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
        ld_chk = 32'h11 ^ 32'h22 ^ 32'h33 ^ 32'h44;
`endif
        send(32'h11, 0);
        step(1);
        send(32'h22, 0);
        ld_last = 1'b1;
        step(1);
        ld_last = 1'b0;
        send(32'h33, 0);
        step(2);
        send(32'h44, 1);
        @(negedge clk);
        chk("gap_count", word_count, 4);
        chk("gap_w1", shadow_mem[1], 32'h22);
        chk("gap_w3", shadow_mem[3], 32'h44);
        chk("gap_w4", shadow_mem[4], 0);
        step(2);

        // Overflow: 64 words, no ld_last
        do_reset();
        step(64);
        for (int i = 0; i < 64; i++) send(32'hA000_0000 + 32'(i), 0);
        @(negedge clk);
        chk("ovf_err", load_error, 1);
        chk("ovf_ready", ld_ready, 0);
        chk("ovf_stall", cpu_stall, 1);
        chk("ovf_count", word_count, 64);
        chk("ovf_w63", shadow_mem[63], 32'hA000_003F);
        ld_valid = 1'b1;
        step(3);
        ld_valid = 1'b0;
        chk("ovf_w0_kept", shadow_mem[0], 32'hA000_0000);

        // Reset during load
        do_reset();
        step(64);
        ld_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            ld_data = 32'hB0 + 32'(i);
            step(1);
        end
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_we", mem_we, 0);
        chk("midrst_count", word_count, 0);
        chk("midrst_ready", ld_ready, 0);
        ld_valid = 1'b0;
        step(1);
        reset = 1'b0;
        @(negedge clk);
        chk("restart_addr", mem_addr, 0);
        chk("restart_we", mem_we, 1);
        step(70);

`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
        do_reset();
        step(64);
        ld_chk = 32'h3;
        send(32'h1, 0);
        send(32'h2, 1);
        @(negedge clk);
        chk("cs_good_done", boot_done, 1);
        chk("cs_good_chkerr", chk_error, 0);

        do_reset();
        step(64);
        ld_chk = 32'h4;
        send(32'h1, 0);
        send(32'h2, 1);
        @(negedge clk);
        chk("cs_bad_chkerr", chk_error, 1);
        chk("cs_bad_loaderr", load_error, 1);
        step(2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
